hazard_match_tracker: RTL
=========================

Name: hazard_match_tracker

Overview:
- Sits directly upstream of the pipeline hazard unit and feeds it. Carries destination-register address and control bits down the E, M and W pipeline stages.
- Compares the register addresses of each stage and produces the Match_* strobes, plus RegWriteM, RegWriteW and MemToRegE, that the hazard unit consumes.
- Takes the hazard unit's FlushE back in to insert bubbles.
- Owns the hazard-relevant sideband; the datapath pipeline registers are owned elsewhere.

Parameters:
- RA_W, 4, register-address width.
- PC_REG, 15, register index that never produces a match (PC reads are not forwarded).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ValidD  input  1  decode stage holds a real instruction (0 = bubble).
- RA1D  input  RA_W  source register 1 of the decode instruction.
- RA2D  input  RA_W  source register 2 of the decode instruction.
- WA3D  input  RA_W  destination register of the decode instruction.
- RegWriteD  input  1  decode instruction writes the register file.
- MemToRegD  input  1  decode instruction is a load.
- FlushE  input  1  from the hazard unit; E stage loads a bubble.
- Match_1E_M  output  1  E.RA1 == M.WA3.
- Match_1E_W  output  1  E.RA1 == W.WA3.
- Match_2E_M  output  1  E.RA2 == M.WA3.
- Match_2E_W  output  1  E.RA2 == W.WA3.
- Match_12D_E  output  1  D.RA1 or D.RA2 == E.WA3.
- RegWriteM  output  1  M-stage register-write enable (valid-qualified).
- RegWriteW  output  1  W-stage register-write enable (valid-qualified).
- MemToRegE  output  1  E-stage load flag (valid-qualified).
- WA3W  output  RA_W  W-stage destination, for register-file write-back.

Behaviour:
- State per stage X in {E, M, W}: ValidX, RA1X, RA2X (E only), WA3X, RegWriteX, MemToRegX (E, M).
- Reset (reset=0, asynchronous): all Valid, RegWrite and MemToReg bits = 0; all address fields = 0.
  - Consequence: every output is 0 during and right after reset.
  - Reset asserted mid-operation clears all stages immediately; there is no partial retire.
- Each rising clk with reset=1:
  - D->E:
    - FlushE=1: ValidE, RegWriteE, MemToRegE <= 0; addresses are don't-care but are loaded with 0.
    - FlushE=0: E <= D fields, ValidE <= ValidD.
  - E->M and M->W: unconditional shift; there is no stall of E, M or W.
  - FlushE does not affect M or W. The instruction in E still advances to M on the same edge.
- The decode-stage stall (StallD) is applied to the upstream instruction register, not here. During a load-use stall the D inputs are held externally, and FlushE=1 inserts exactly one bubble into E per stalled cycle.
- Outputs are purely combinational from registered state and the D inputs. There is no added latency, so the hazard unit sees matches in the same cycle.
- Match rules:
  - A match requires address equality AND the producing stage valid AND the producer address != PC_REG.
  - Match_*E_* additionally requires ValidE.
  - Match_12D_E requires ValidD, ValidE and RegWriteE.
  - Match_*_M / _W do not AND in RegWrite; the hazard unit does that.
- RegWriteM = ValidM & RegWriteM_reg; RegWriteW = ValidW & RegWriteW_reg; MemToRegE = ValidE & MemToRegE_reg.
- Simultaneous cases:
  - M and W both match: both strobes assert; the hazard unit prioritises M.
  - Same register on RA1 and RA2: both strobes assert.
- Bubble stages never match, even when address fields compare equal, e.g. 0 == 0 after reset.

Test Plan:
- Reset: hold reset=0 with random D inputs and clock running -> all outputs 0. Release reset -> outputs stay 0 until a valid instruction reaches E.
- EX forwarding: cycle 0 D = {WA3=3, RegWrite=1}; cycle 1 D = {RA1=3, RA2=5}. When the second instruction is in E -> Match_1E_M=1, RegWriteM=1, Match_2E_M=0. One cycle later -> Match_1E_W=1, RegWriteW=1, WA3W=3.
- Load-use: LDR {WA3=2, MemToReg=1, RegWrite=1} in E, D has RA2=2 -> Match_12D_E=1, MemToRegE=1. Drive FlushE=1 for one edge -> E becomes a bubble (MemToRegE=0, Match_12D_E=0) and the LDR is in M.
- PC exclusion: producer WA3=15, consumer RA1=15 -> all Match_* remain 0.
- Bubble immunity: after reset, inject ValidD=1 with RA1=RA2=0 and no prior writes -> no Match asserted despite zeroed address fields.
- Async reset mid-pipe: three valid instructions in flight, pull reset low between clock edges -> RegWriteM, RegWriteW, MemToRegE and all Match_* go 0 without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_match_tracker.sv
// Hazard sideband pipeline: carries destination and control bits through E/M/W
// and produces the register-match strobes consumed by the hazard unit.
module hazard_match_tracker #(
  parameter int RA_W   = 4,
  parameter int PC_REG = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ValidD,
  input  logic [RA_W-1:0] RA1D,
  input  logic [RA_W-1:0] RA2D,
  input  logic [RA_W-1:0] WA3D,
  input  logic            RegWriteD,
  input  logic            MemToRegD,
  input  logic            FlushE,
  output logic            Match_1E_M,
  output logic            Match_1E_W,
  output logic            Match_2E_M,
  output logic            Match_2E_W,
  output logic            Match_12D_E,
  output logic            RegWriteM,
  output logic            RegWriteW,
  output logic            MemToRegE,
  output logic [RA_W-1:0] WA3W
);

  localparam logic [RA_W-1:0] PC_ADDR = RA_W'(PC_REG);

  logic            valid_e_r, reg_write_e_r, mem_to_reg_e_r;
  logic [RA_W-1:0] ra1_e_r, ra2_e_r, wa3_e_r;
  logic            valid_m_r, reg_write_m_r;
  logic [RA_W-1:0] wa3_m_r;
  logic            valid_w_r, reg_write_w_r;
  logic [RA_W-1:0] wa3_w_r;

  logic            prod_e_s, prod_m_s, prod_w_s;

  // Stage registers: D->E with flush-to-bubble, E->M->W unconditional shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_e_r      <= 1'b0;
      reg_write_e_r  <= 1'b0;
      mem_to_reg_e_r <= 1'b0;
      ra1_e_r        <= {RA_W{1'b0}};
      ra2_e_r        <= {RA_W{1'b0}};
      wa3_e_r        <= {RA_W{1'b0}};
      valid_m_r      <= 1'b0;
      reg_write_m_r  <= 1'b0;
      wa3_m_r        <= {RA_W{1'b0}};
      valid_w_r      <= 1'b0;
      reg_write_w_r  <= 1'b0;
      wa3_w_r        <= {RA_W{1'b0}};
    end else begin
      valid_w_r     <= valid_m_r;
      reg_write_w_r <= reg_write_m_r;
      wa3_w_r       <= wa3_m_r;
      valid_m_r     <= valid_e_r;
      reg_write_m_r <= reg_write_e_r;
      wa3_m_r       <= wa3_e_r;
      if (FlushE) begin
        valid_e_r      <= 1'b0;
        reg_write_e_r  <= 1'b0;
        mem_to_reg_e_r <= 1'b0;
        ra1_e_r        <= {RA_W{1'b0}};
        ra2_e_r        <= {RA_W{1'b0}};
        wa3_e_r        <= {RA_W{1'b0}};
      end else begin
        valid_e_r      <= ValidD;
        reg_write_e_r  <= RegWriteD;
        mem_to_reg_e_r <= MemToRegD;
        ra1_e_r        <= RA1D;
        ra2_e_r        <= RA2D;
        wa3_e_r        <= WA3D;
      end
    end
  end

  // A stage can only be matched against when it holds a real, non-PC producer.
  assign prod_e_s = valid_e_r & (wa3_e_r != PC_ADDR);
  assign prod_m_s = valid_m_r & (wa3_m_r != PC_ADDR);
  assign prod_w_s = valid_w_r & (wa3_w_r != PC_ADDR);

  assign Match_1E_M  = valid_e_r & prod_m_s & (ra1_e_r == wa3_m_r);
  assign Match_1E_W  = valid_e_r & prod_w_s & (ra1_e_r == wa3_w_r);
  assign Match_2E_M  = valid_e_r & prod_m_s & (ra2_e_r == wa3_m_r);
  assign Match_2E_W  = valid_e_r & prod_w_s & (ra2_e_r == wa3_w_r);
  assign Match_12D_E = ValidD & prod_e_s & reg_write_e_r &
                       ((RA1D == wa3_e_r) | (RA2D == wa3_e_r));

  assign RegWriteM = valid_m_r & reg_write_m_r;
  assign RegWriteW = valid_w_r & reg_write_w_r;
  assign MemToRegE = valid_e_r & mem_to_reg_e_r;
  assign WA3W      = wa3_w_r;

endmodule
